psram_timer_bank: RTL and testbench
===================================

# psram_timer_bank

Parametrised, multi-channel successor to the fixed PSRAM timing checker. Tracks NUM_TMR independent, CSR-programmed timing windows (tRC, tCPH, tCEM, tRST, tXHS, tXDPD or future parameters) relative to CE# edges, with per-channel arming phase, span mode and ignore. Reports sticky expiry, a one-cycle expiry pulse and early-deassertion violations. Sits between the CSR bank and data_shifter; data_shifter consumes expiry and violation flags to gate the next transfer.

## Interface
- NUM_TMR, default 6: number of timer channels (1..16).
- CNT_W, default 16: counter and limit width per channel (4..20).
- mem_clk  in  1: memory-domain clock; all logic on rising edge.
- rst  in  1: asynchronous, active-high reset; clears all state and outputs.
- ce_n_ip  in  1: CE# as driven to the PSRAM, synchronous to mem_clk.
- tmr_en  in  NUM_TMR: channel enable; low forces the channel to IDLE.
- tmr_arm_rise  in  NUM_TMR: 1 = arm on CE# rising (high phase), 0 = arm on CE# falling (low phase).
- tmr_span  in  NUM_TMR: 1 = keep counting after arming regardless of CE#; 0 = count only while CE# stays in the arming phase.
- tmr_ignore  in  NUM_TMR: channel expires on the edge after arming, counter unused.
- tmr_limit  in  NUM_TMR*CNT_W: packed limits; channel i uses bits [i*CNT_W +: CNT_W].
- tmr_clr  in  1: single-cycle pulse; clears all expired and violation flags and returns EXPIRED channels to IDLE.
- tmr_expired  out  NUM_TMR: sticky expiry per channel.
- tmr_expired_pls  out  NUM_TMR: one-cycle pulse on the 0->1 transition of tmr_expired.
- tmr_early  out  NUM_TMR: sticky; CE# left the arming phase before expiry (span=0 only).
- all_expired  out  1: AND of tmr_expired over enabled channels; 0 when no channel is enabled.

## Operation
- CE# edge detect: ce_n_q registers ce_n_ip (reset value 1). Rise = ce_n_ip & ~ce_n_q; fall = ~ce_n_ip & ce_n_q. Arm event for channel i = rise when tmr_arm_rise[i] = 1, else fall.
- Per-channel states: IDLE, COUNT, EXPIRED. Counter cnt is CNT_W bits.
- IDLE: on arm event (with tmr_en=1), go to COUNT with cnt=0. Other inputs are ignored.
- COUNT: if tmr_ignore or cnt==limit, go to EXPIRED and set expired and pulse. Otherwise, if span=0 and CE# is out of phase, set early and go to IDLE. Otherwise cnt+1.
- The expiry check takes priority over the out-of-phase check in the same cycle.
- A new arm event in COUNT (possible only with span=1) restarts cnt=0 and is not a violation.
- EXPIRED: hold, with cnt frozen. An arm event re-enters COUNT with cnt=0 and clears expired. tmr_clr goes to IDLE.
- tmr_clr and an arm event in the same cycle: the arm wins; expired and early are cleared and COUNT starts.
- tmr_en low: the next edge sends the channel to IDLE and clears cnt, expired and early. Limit or mode changes take effect on the next comparison.
- cnt never wraps: limit ≤ 2^CNT_W−1, and expiry fires at equality before any overflow.

## Timing
- Reset values: all outputs 0; states IDLE; cnt 0; ce_n_q 1.
- Arm edge E0 is the clock edge that first samples the new CE# level. tmr_expired rises at edge E0+limit+1, or E0+1 with ignore. tmr_expired_pls is high for exactly that one cycle.
- tmr_early rises on the edge that first samples the out-of-phase CE# level.
- all_expired is combinational from registered flags, so it has zero added latency.
- Reset asserted mid-count aborts immediately with no pulse. After release, CE# must present a fresh edge relative to ce_n_q=1 before any channel arms.

## Structure
- Package psram_tmr_pkg holds:
  - state enum tmr_state_t (IDLE, COUNT, EXPIRED);
  - localparams ARM_FALL=0, ARM_RISE=1, SPAN_PHASE=0, SPAN_CYCLE=1;
  - default channel indices TMR_RC, TMR_CPH, TMR_CEM, TMR_RST, TMR_XHS, TMR_XDPD.
- Sub-module psram_tmr_chan: one channel's state, counter, flags and pulse. It is generated NUM_TMR times.
- The top level holds the CE# edge detect, limit unpacking and the all_expired reduction.

## Test plan
- Ch0 set to arm_rise=0, span=1, limit=5; CE# falls at E0 -> expired at E0+6, one-cycle pulse, and it stays set after CE# rises.
- Ch1 set to arm_rise=1, span=0, limit=3; CE# high for 2 cycles then low -> early=1, expired=0, state IDLE. Repeat with 4 high cycles -> expired=1, early=0.
- Ch2 with ignore=1, limit=0xFFFF; CE# falls -> expired at E0+1. Then tmr_clr in the same cycle as the next CE# fall -> expired cleared and COUNT restarted, so expired returns at E+1.
- NUM_TMR=3, CNT_W=4, limit=15 -> expiry at E0+16 with no counter wrap. tmr_en dropped mid-count -> all flags 0 next cycle.
- all_expired with only ch0/ch2 enabled -> rises only when both are expired; disabling all channels -> 0.
- rst asserted 2 cycles before an expected expiry -> no pulse, outputs 0. After release, CE# held low with no edge -> no channel arms.

Source files
------------

// File: rtl/psram_tmr_pkg.sv
// Shared types and constants for the PSRAM timing-window checker bank.
package psram_tmr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2
    } tmr_state_t;

    localparam logic ARM_FALL   = 1'b0;
    localparam logic ARM_RISE   = 1'b1;
    localparam logic SPAN_PHASE = 1'b0;
    localparam logic SPAN_CYCLE = 1'b1;

    localparam int TMR_RC   = 0;
    localparam int TMR_CPH  = 1;
    localparam int TMR_CEM  = 2;
    localparam int TMR_RST  = 3;
    localparam int TMR_XHS  = 4;
    localparam int TMR_XDPD = 5;

    // Arming edge for a channel, selected by its arm-phase bit.
    function automatic logic arm_event(input logic arm_rise, input logic rise, input logic fall);
        return (arm_rise == ARM_RISE) ? rise : fall;
    endfunction

endpackage

// File: rtl/psram_tmr_chan.sv
// One timing-window channel: state, counter, sticky expiry/early flags and expiry pulse.
// state   | meaning
// IDLE    | waiting for this channel's CE# arming edge
// COUNT   | counting cycles since the arming edge
// EXPIRED | window elapsed; counter frozen, expired flag held
module psram_tmr_chan
    import psram_tmr_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             mem_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             arm,
    input  logic             in_phase,
    input  logic             span,
    input  logic             ignore,
    input  logic [CNT_W-1:0] limit,
    input  logic             clr,
    output logic             expired,
    output logic             expired_pls,
    output logic             early
);

    tmr_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;
    logic             early_q, early_d;
    logic             pls_q, pls_d;

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            expired_q <= 1'b0;
            early_q   <= 1'b0;
            pls_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
            early_q   <= early_d;
            pls_q     <= pls_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        expired_d = expired_q;
        early_d   = early_q;
        pls_d     = 1'b0;

        if (clr) begin
            expired_d = 1'b0;
            early_d   = 1'b0;
        end

        if (!en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            expired_d = 1'b0;
            early_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d = COUNT;
                        cnt_d   = '0;
                    end
                end
                COUNT: begin
                    // Expiry outranks the out-of-phase check in the same cycle.
                    if (arm) begin
                        cnt_d = '0;
                    end else if (ignore || (cnt_q == limit)) begin
                        state_d   = EXPIRED;
                        expired_d = 1'b1;
                        pls_d     = ~expired_q;
                    end else if ((span == SPAN_PHASE) && !in_phase) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        early_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                EXPIRED: begin
                    if (arm) begin
                        state_d   = COUNT;
                        cnt_d     = '0;
                        expired_d = 1'b0;
                        early_d   = 1'b0;
                    end else if (clr) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign expired     = expired_q;
    assign expired_pls = pls_q;
    assign early       = early_q;

endmodule

// File: rtl/psram_timer_bank.sv
// Bank of CSR-programmed PSRAM timing windows referenced to CE# edges.
module psram_timer_bank
    import psram_tmr_pkg::*;
#(
    parameter int NUM_TMR = 6,
    parameter int CNT_W   = 16
) (
    input  logic                     mem_clk,
    input  logic                     rst,
    input  logic                     ce_n_ip,
    input  logic [NUM_TMR-1:0]       tmr_en,
    input  logic [NUM_TMR-1:0]       tmr_arm_rise,
    input  logic [NUM_TMR-1:0]       tmr_span,
    input  logic [NUM_TMR-1:0]       tmr_ignore,
    input  logic [NUM_TMR*CNT_W-1:0] tmr_limit,
    input  logic                     tmr_clr,
    output logic [NUM_TMR-1:0]       tmr_expired,
    output logic [NUM_TMR-1:0]       tmr_expired_pls,
    output logic [NUM_TMR-1:0]       tmr_early,
    output logic                     all_expired
);

    logic ce_n_q;
    logic ce_rise;
    logic ce_fall;

    // Reset value 1 means a CE# held low out of reset looks like a falling edge.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) ce_n_q <= 1'b1;
        else     ce_n_q <= ce_n_ip;
    end

    assign ce_rise = ce_n_ip & ~ce_n_q;
    assign ce_fall = ~ce_n_ip & ce_n_q;

    for (genvar g = 0; g < NUM_TMR; g++) begin : g_chan
        logic arm;
        logic in_phase;

        assign arm      = arm_event(tmr_arm_rise[g], ce_rise, ce_fall);
        assign in_phase = (tmr_arm_rise[g] == ARM_RISE) ? ce_n_ip : ~ce_n_ip;

        psram_tmr_chan #(.CNT_W(CNT_W)) u_chan (
            .mem_clk     (mem_clk),
            .rst         (rst),
            .en          (tmr_en[g]),
            .arm         (arm),
            .in_phase    (in_phase),
            .span        (tmr_span[g]),
            .ignore      (tmr_ignore[g]),
            .limit       (tmr_limit[g*CNT_W +: CNT_W]),
            .clr         (tmr_clr),
            .expired     (tmr_expired[g]),
            .expired_pls (tmr_expired_pls[g]),
            .early       (tmr_early[g])
        );
    end

    assign all_expired = (|tmr_en) & (&(tmr_expired | ~tmr_en));

endmodule

// File: tb/tb_psram_timer_bank.sv
// Scenario bench for psram_timer_bank: expected expiry edges queued at stimulus, checked on pulses.
module tb_psram_timer_bank;
    import psram_tmr_pkg::*;

    localparam int N = 3;
    localparam int W = 4;

    logic           mem_clk = 1'b0;
    logic           rst     = 1'b1;
    logic           ce_n_ip = 1'b1;
    logic [N-1:0]   tmr_en       = '0;
    logic [N-1:0]   tmr_arm_rise = '0;
    logic [N-1:0]   tmr_span     = '0;
    logic [N-1:0]   tmr_ignore   = '0;
    logic [N*W-1:0] tmr_limit    = '0;
    logic           tmr_clr      = 1'b0;
    logic [N-1:0]   tmr_expired;
    logic [N-1:0]   tmr_expired_pls;
    logic [N-1:0]   tmr_early;
    logic           all_expired;

    psram_timer_bank #(.NUM_TMR(N), .CNT_W(W)) dut (
        .mem_clk         (mem_clk),
        .rst             (rst),
        .ce_n_ip         (ce_n_ip),
        .tmr_en          (tmr_en),
        .tmr_arm_rise    (tmr_arm_rise),
        .tmr_span        (tmr_span),
        .tmr_ignore      (tmr_ignore),
        .tmr_limit       (tmr_limit),
        .tmr_clr         (tmr_clr),
        .tmr_expired     (tmr_expired),
        .tmr_expired_pls (tmr_expired_pls),
        .tmr_early       (tmr_early),
        .all_expired     (all_expired)
    );

    always #5 mem_clk = ~mem_clk;

    int cyc = 0;
    always @(posedge mem_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic set_lim(input int ch, input int v);
        logic [W-1:0] lv;
        lv = v[W-1:0];
        tmr_limit[ch*W +: W] = lv;
    endtask

    task automatic pulse_clr();
        tmr_clr = 1'b1;
        tick();
        tmr_clr = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if (tmr_expired !== '0) begin n_err++; $display("FAIL reset_expired got %b want 000", tmr_expired); end
        n_cmp++;
        if (tmr_expired_pls !== '0) begin n_err++; $display("FAIL reset_pls got %b want 000", tmr_expired_pls); end
        n_cmp++;
        if (tmr_early !== '0) begin n_err++; $display("FAIL reset_early got %b want 000", tmr_early); end
        n_cmp++;
        if (all_expired !== 1'b0) begin n_err++; $display("FAIL reset_all got %b want 0", all_expired); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_span_expiry();
        int npls;
        int e;
        tmr_en = 3'b001;
        tmr_arm_rise[TMR_RC] = ARM_FALL;
        tmr_span[TMR_RC]     = SPAN_CYCLE;
        set_lim(TMR_RC, 5);
        ce_n_ip = 1'b1;
        tick();
        tick();
        ce_n_ip = 1'b0;
        exp_q.push_back(cyc + 1 + 5 + 1);
        npls = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 2) ce_n_ip = 1'b1;
            if (tmr_expired_pls[TMR_RC]) begin
                npls++;
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL span_extra_pulse at cycle %0d", cyc); end
                else begin
                    e = exp_q.pop_front();
                    if (cyc !== e) begin n_err++; $display("FAIL span_pulse_cycle got %0d want %0d", cyc, e); end
                end
                n_cmp++;
                if (tmr_expired[TMR_RC] !== 1'b1) begin n_err++; $display("FAIL span_exp_with_pulse got 0 want 1"); end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL span_timeout pending %0d want 0", exp_q.size()); exp_q.delete(); end
        n_cmp++;
        if (npls != 1) begin n_err++; $display("FAIL span_pulse_count got %0d want 1", npls); end
        n_cmp++;
        if (tmr_expired[TMR_RC] !== 1'b1) begin n_err++; $display("FAIL span_sticky got %b want 1", tmr_expired[TMR_RC]); end
        n_cmp++;
        if (tmr_early[TMR_RC] !== 1'b0) begin n_err++; $display("FAIL span_early got %b want 0", tmr_early[TMR_RC]); end
    endtask

    task automatic test_early();
        int e0;
        int hi;
        int early_cyc;
        int e;
        pulse_clr();
        tmr_en = 3'b010;
        tmr_arm_rise[TMR_CPH] = ARM_RISE;
        tmr_span[TMR_CPH]     = SPAN_PHASE;
        set_lim(TMR_CPH, 3);
        ce_n_ip = 1'b0;
        tick();
        tick();
        for (int rep = 0; rep < 2; rep++) begin
            hi = (rep == 0) ? 2 : 4;
            ce_n_ip = 1'b1;
            e0 = cyc + 1;
            if (rep == 1) exp_q.push_back(e0 + 3 + 1);
            for (int k = 0; k < hi; k++) tick();
            ce_n_ip = 1'b0;
            early_cyc = -1;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (tmr_early[TMR_CPH] && early_cyc < 0) early_cyc = cyc;
                if (tmr_expired_pls[TMR_CPH]) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin n_err++; $display("FAIL early_extra_pulse rep %0d at cycle %0d", rep, cyc); end
                    else begin
                        e = exp_q.pop_front();
                        if (cyc !== e) begin n_err++; $display("FAIL early_pulse_cycle got %0d want %0d", cyc, e); end
                    end
                end
            end
            n_cmp++;
            if (exp_q.size() != 0) begin n_err++; $display("FAIL early_timeout rep %0d pending %0d want 0", rep, exp_q.size()); exp_q.delete(); end
            if (rep == 0) begin
                n_cmp++;
                if (early_cyc !== e0 + 2) begin n_err++; $display("FAIL early_cycle got %0d want %0d", early_cyc, e0 + 2); end
                n_cmp++;
                if (tmr_expired[TMR_CPH] !== 1'b0) begin n_err++; $display("FAIL early_no_exp got %b want 0", tmr_expired[TMR_CPH]); end
                n_cmp++;
                if (tmr_early[TMR_CPH] !== 1'b1) begin n_err++; $display("FAIL early_sticky got %b want 1", tmr_early[TMR_CPH]); end
                pulse_clr();
            end else begin
                n_cmp++;
                if (tmr_expired[TMR_CPH] !== 1'b1) begin n_err++; $display("FAIL long_exp got %b want 1", tmr_expired[TMR_CPH]); end
                n_cmp++;
                if (tmr_early[TMR_CPH] !== 1'b0) begin n_err++; $display("FAIL long_early got %b want 0", tmr_early[TMR_CPH]); end
            end
        end
    endtask

    task automatic test_ignore();
        int e;
        pulse_clr();
        tmr_en = 3'b100;
        tmr_arm_rise[TMR_CEM] = ARM_FALL;
        tmr_span[TMR_CEM]     = SPAN_CYCLE;
        tmr_ignore[TMR_CEM]   = 1'b1;
        set_lim(TMR_CEM, 15);
        ce_n_ip = 1'b1;
        tick();
        tick();
        for (int rep = 0; rep < 2; rep++) begin
            ce_n_ip = 1'b0;
            exp_q.push_back(cyc + 2);
            if (rep == 1) begin
                tmr_clr = 1'b1;
                tick();
                tmr_clr = 1'b0;
                n_cmp++;
                if (tmr_expired[TMR_CEM] !== 1'b0) begin n_err++; $display("FAIL ign_clr_arm got %b want 0", tmr_expired[TMR_CEM]); end
            end
            for (int k = 0; k < 4; k++) begin
                tick();
                if (tmr_expired_pls[TMR_CEM]) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin n_err++; $display("FAIL ign_extra_pulse at cycle %0d", cyc); end
                    else begin
                        e = exp_q.pop_front();
                        if (cyc !== e) begin n_err++; $display("FAIL ign_pulse_cycle rep %0d got %0d want %0d", rep, cyc, e); end
                    end
                end
            end
            n_cmp++;
            if (exp_q.size() != 0) begin n_err++; $display("FAIL ign_timeout rep %0d pending %0d want 0", rep, exp_q.size()); exp_q.delete(); end
            n_cmp++;
            if (tmr_expired[TMR_CEM] !== 1'b1) begin n_err++; $display("FAIL ign_exp rep %0d got %b want 1", rep, tmr_expired[TMR_CEM]); end
            ce_n_ip = 1'b1;
            tick();
            tick();
        end
        tmr_ignore[TMR_CEM] = 1'b0;
    endtask

    task automatic test_wide_limit();
        int e0;
        int e;
        pulse_clr();
        tmr_en = 3'b001;
        tmr_arm_rise[TMR_RC] = ARM_FALL;
        tmr_span[TMR_RC]     = SPAN_CYCLE;
        set_lim(TMR_RC, 15);
        ce_n_ip = 1'b1;
        tick();
        tick();
        ce_n_ip = 1'b0;
        e0 = cyc + 1;
        exp_q.push_back(e0 + 16);
        for (int k = 0; k < 24; k++) begin
            tick();
            if (cyc == e0 + 15) begin
                n_cmp++;
                if (tmr_expired[TMR_RC] !== 1'b0) begin n_err++; $display("FAIL wide_early_exp got %b want 0", tmr_expired[TMR_RC]); end
            end
            if (tmr_expired_pls[TMR_RC]) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL wide_extra_pulse at cycle %0d", cyc); end
                else begin
                    e = exp_q.pop_front();
                    if (cyc !== e) begin n_err++; $display("FAIL wide_pulse_cycle got %0d want %0d", cyc, e); end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL wide_timeout pending %0d want 0", exp_q.size()); exp_q.delete(); end
        n_cmp++;
        if (tmr_expired[TMR_RC] !== 1'b1) begin n_err++; $display("FAIL wide_exp got %b want 1", tmr_expired[TMR_RC]); end

        tmr_en = 3'b011;
        tmr_arm_rise[TMR_CPH] = ARM_RISE;
        tmr_span[TMR_CPH]     = SPAN_CYCLE;
        set_lim(TMR_CPH, 10);
        ce_n_ip = 1'b1;
        tick();
        tick();
        tick();
        tmr_en = 3'b000;
        tick();
        n_cmp++;
        if ({tmr_expired, tmr_early, tmr_expired_pls, all_expired} !== '0)
            begin n_err++; $display("FAIL en_drop got exp %b early %b pls %b all %b want all 0", tmr_expired, tmr_early, tmr_expired_pls, all_expired); end
        tmr_en = 3'b011;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (tmr_expired_pls != '0) begin
                n_cmp++;
                n_err++;
                $display("FAIL en_restart_pulse got %b want 000 at cycle %0d", tmr_expired_pls, cyc);
            end
        end
        n_cmp++;
        if (tmr_expired !== '0) begin n_err++; $display("FAIL en_restart_exp got %b want 000", tmr_expired); end
    endtask

    task automatic test_all_expired();
        int e0;
        logic want;
        tmr_en = 3'b000;
        tick();
        tmr_en = 3'b101;
        tmr_arm_rise[TMR_RC]  = ARM_FALL;
        tmr_span[TMR_RC]      = SPAN_CYCLE;
        set_lim(TMR_RC, 2);
        tmr_arm_rise[TMR_CEM] = ARM_FALL;
        tmr_ignore[TMR_CEM]   = 1'b1;
        ce_n_ip = 1'b1;
        tick();
        ce_n_ip = 1'b0;
        e0 = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            want = (cyc >= e0 + 3) && (cyc >= e0 + 1);
            n_cmp++;
            if (all_expired !== want) begin n_err++; $display("FAIL all_exp cycle %0d got %b want %b", cyc - e0, all_expired, want); end
        end
        tmr_en = 3'b000;
        #1;
        n_cmp++;
        if (all_expired !== 1'b0) begin n_err++; $display("FAIL all_none_enabled got %b want 0", all_expired); end
        tick();
        tmr_ignore[TMR_CEM] = 1'b0;
    endtask

    task automatic test_reset_mid();
        tmr_en = 3'b001;
        tmr_arm_rise[TMR_RC] = ARM_RISE;
        tmr_span[TMR_RC]     = SPAN_CYCLE;
        set_lim(TMR_RC, 6);
        ce_n_ip = 1'b0;
        tick();
        tick();
        ce_n_ip = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({tmr_expired, tmr_early, tmr_expired_pls, all_expired} !== '0)
            begin n_err++; $display("FAIL rst_mid got exp %b early %b pls %b want all 0", tmr_expired, tmr_early, tmr_expired_pls); end
        ce_n_ip = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (tmr_expired_pls != '0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rst_hold_pulse got %b want 000", tmr_expired_pls);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (tmr_expired_pls != '0 || tmr_expired != '0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rst_rearm got exp %b pls %b want 000", tmr_expired, tmr_expired_pls);
            end
        end
        n_cmp++;
        if (tmr_expired !== '0) begin n_err++; $display("FAIL rst_no_arm got %b want 000", tmr_expired); end
    endtask

    initial begin
        test_reset();
        test_span_expiry();
        test_early();
        test_ignore();
        test_wide_limit();
        test_all_expired();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
